// File: rtl/axi4_lite_pkg.sv
// Shared constants, FSM state types and helpers
// for the AXI4-Lite register slave.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Byte address to register index, with range check
// covering both the index and any higher address bits.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 16,
  localparam int IDX_W =
    (clog2(REG_COUNT) > 1) ? clog2(REG_COUNT) : 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_in_range
);

  localparam int LSB = clog2(DATA_W / 8);
  localparam int HI  = LSB + IDX_W;
  localparam logic [IDX_W:0] CNT = (IDX_W + 1)'(REG_COUNT);

  logic [ADDR_W-1:0] w_hi;

  assign o_idx      = i_addr[LSB +: IDX_W];
  assign w_hi       = i_addr >> HI;
  assign o_in_range = ({1'b0, o_idx} < CNT) && (w_hi == '0);

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing a bank of byte-writable registers
// with a one-cycle write-notify strobe to user logic.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int REG_COUNT        = 16,
  localparam int IDX_W =
    (clog2(REG_COUNT) > 1) ? clog2(REG_COUNT) : 1,
  localparam int DW = C_AXI_DATA_WIDTH,
  localparam int SW = C_AXI_DATA_WIDTH / 8
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESET,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [2:0]                  S_AXI_AWPROT,
  input  logic [DW-1:0]               S_AXI_WDATA,
  input  logic [SW-1:0]               S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [2:0]                  S_AXI_ARPROT,
  output logic [DW-1:0]               S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [REG_COUNT*DW-1:0]     REG_Q,
  output logic                        REG_WSTB,
  output logic [IDX_W-1:0]            REG_WIDX
);

  wstate_t r_wstate, w_wstate_n;
  rstate_t r_rstate, w_rstate_n;

  logic r_awready, w_awready_n;
  logic r_wready, w_wready_n;
  logic r_aw_done, w_aw_done_n;
  logic r_w_done, w_w_done_n;
  logic [IDX_W-1:0] r_aw_idx, w_aw_idx_n;
  logic r_aw_ok, w_aw_ok_n;
  logic [DW-1:0] r_wdata, w_wdata_n;
  logic [SW-1:0] r_wstrb, w_wstrb_n;
  logic r_bvalid, w_bvalid_n;
  logic [1:0] r_bresp, w_bresp_n;
  logic r_wstb, w_wstb_n;
  logic [IDX_W-1:0] r_widx, w_widx_n;

  logic r_arready, w_arready_n;
  logic r_rvalid, w_rvalid_n;
  logic [1:0] r_rresp, w_rresp_n;
  logic [DW-1:0] r_rdata, w_rdata_n;

  logic [DW-1:0] r_regs [REG_COUNT];

  logic [IDX_W-1:0] w_awdec_idx, w_ardec_idx, w_cidx;
  logic w_awdec_ok, w_ardec_ok, w_cok;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [DW-1:0] w_cdata;
  logic [SW-1:0] w_cstrb;
  logic w_unused_prot;

  assign w_unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  axi4_lite_addr_decode #(
    .ADDR_W    (C_AXI_ADDR_WIDTH),
    .DATA_W    (DW),
    .REG_COUNT (REG_COUNT)
  ) u_aw_dec (
    .i_addr     (S_AXI_AWADDR),
    .o_idx      (w_awdec_idx),
    .o_in_range (w_awdec_ok)
  );

  axi4_lite_addr_decode #(
    .ADDR_W    (C_AXI_ADDR_WIDTH),
    .DATA_W    (DW),
    .REG_COUNT (REG_COUNT)
  ) u_ar_dec (
    .i_addr     (S_AXI_ARADDR),
    .o_idx      (w_ardec_idx),
    .o_in_range (w_ardec_ok)
  );

  assign w_aw_hs = r_awready & S_AXI_AWVALID;
  assign w_w_hs  = r_wready & S_AXI_WVALID;
  assign w_ar_hs = r_arready & S_AXI_ARVALID;

  // Live beat wins over the latched copy when it lands this edge
  assign w_cidx  = w_aw_hs ? w_awdec_idx : r_aw_idx;
  assign w_cok   = w_aw_hs ? w_awdec_ok : r_aw_ok;
  assign w_cdata = w_w_hs ? S_AXI_WDATA : r_wdata;
  assign w_cstrb = w_w_hs ? S_AXI_WSTRB : r_wstrb;

  always_comb begin
    w_wstate_n  = r_wstate;
    w_awready_n = r_awready;
    w_wready_n  = r_wready;
    w_aw_done_n = r_aw_done;
    w_w_done_n  = r_w_done;
    w_aw_idx_n  = r_aw_idx;
    w_aw_ok_n   = r_aw_ok;
    w_wdata_n   = r_wdata;
    w_wstrb_n   = r_wstrb;
    w_bvalid_n  = r_bvalid;
    w_bresp_n   = r_bresp;
    w_wstb_n    = 1'b0;
    w_widx_n    = r_widx;
    w_commit    = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_aw_done_n = r_aw_done | w_aw_hs;
        w_w_done_n  = r_w_done | w_w_hs;
        w_aw_idx_n  = w_cidx;
        w_aw_ok_n   = w_cok;
        w_wdata_n   = w_cdata;
        w_wstrb_n   = w_cstrb;
        w_awready_n = ~w_aw_done_n;
        w_wready_n  = ~w_w_done_n;
        if (w_aw_done_n && w_w_done_n) begin
          w_commit    = w_cok;
          w_wstb_n    = w_cok;
          w_widx_n    = w_cok ? w_cidx : r_widx;
          w_bvalid_n  = 1'b1;
          w_bresp_n   = w_cok ? RESP_OKAY : RESP_SLVERR;
          w_awready_n = 1'b0;
          w_wready_n  = 1'b0;
          w_aw_done_n = 1'b0;
          w_w_done_n  = 1'b0;
          w_wstate_n  = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_bvalid_n  = 1'b0;
          w_awready_n = 1'b1;
          w_wready_n  = 1'b1;
          w_wstate_n  = W_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_rstate_n  = r_rstate;
    w_arready_n = r_arready;
    w_rvalid_n  = r_rvalid;
    w_rresp_n   = r_rresp;
    w_rdata_n   = r_rdata;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready_n = 1'b1;
        if (w_ar_hs) begin
          w_rdata_n   = w_ardec_ok ? r_regs[w_ardec_idx] : '0;
          w_rresp_n   = w_ardec_ok ? RESP_OKAY : RESP_SLVERR;
          w_rvalid_n  = 1'b1;
          w_arready_n = 1'b0;
          w_rstate_n  = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          w_rvalid_n  = 1'b0;
          w_arready_n = 1'b1;
          w_rstate_n  = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_ok   <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_wstb    <= 1'b0;
      r_widx    <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      r_wstate  <= w_wstate_n;
      r_rstate  <= w_rstate_n;
      r_awready <= w_awready_n;
      r_wready  <= w_wready_n;
      r_aw_done <= w_aw_done_n;
      r_w_done  <= w_w_done_n;
      r_aw_idx  <= w_aw_idx_n;
      r_aw_ok   <= w_aw_ok_n;
      r_wdata   <= w_wdata_n;
      r_wstrb   <= w_wstrb_n;
      r_bvalid  <= w_bvalid_n;
      r_bresp   <= w_bresp_n;
      r_wstb    <= w_wstb_n;
      r_widx    <= w_widx_n;
      r_arready <= w_arready_n;
      r_rvalid  <= w_rvalid_n;
      r_rresp   <= w_rresp_n;
      r_rdata   <= w_rdata_n;
      for (int i = 0; i < REG_COUNT; i++) begin
        if (w_commit && w_cidx == IDX_W'(i)) begin
          for (int b = 0; b < SW; b++) begin
            if (w_cstrb[b]) r_regs[i][b*8 +: 8] <= w_cdata[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_q
    assign REG_Q[g*DW +: DW] = r_regs[g];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign REG_WSTB      = r_wstb;
  assign REG_WIDX      = r_widx;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Randomized self-checking bench for axi4_lite_slave_regs
// against a flat register-array model.
module tb_axi4_lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [511:0] REG_Q;
  logic        REG_WSTB;
  logic [3:0]  REG_WIDX;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  axi4_lite_slave_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .REG_Q         (REG_Q),
    .REG_WSTB      (REG_WSTB),
    .REG_WIDX      (REG_WIDX)
  );

  function automatic logic [511:0] model_q();
    logic [511:0] e;
    for (int i = 0; i < 16; i++) e[i*32 +: 32] = model[i];
    return e;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return a < 32'd64;
  endfunction

  function automatic void model_write(
    input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a >> 2][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  // Drives one write; viol counts protocol breaches seen on the way
  task automatic bus_write(
    input logic [31:0] addr, input logic [31:0] data,
    input logic [3:0] strb, input int awd, input int wd,
    input int bstall, output logic [1:0] resp,
    output logic wstb, output logic [3:0] widx, output int viol);
    int cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    viol = 0; cyc = 0; aw_done = 0; w_done = 0;
    resp = 2'b11; wstb = 1'b0; widx = '0;
    while (!(aw_done && w_done)) begin
      if (cyc >= 40) begin
        viol++;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        return;
      end
      @(negedge clk);
      if (aw_done && S_AXI_AWREADY) viol++;
      if (w_done && S_AXI_WREADY) viol++;
      S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_AWVALID = !aw_done && (cyc >= awd);
      S_AXI_WVALID = !w_done && (cyc >= wd);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge clk);
      aw_done |= aw_hs; w_done |= w_hs; cyc++;
    end
    #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    resp = S_AXI_BRESP; wstb = REG_WSTB; widx = REG_WIDX;
    if (!S_AXI_BVALID || S_AXI_AWREADY || S_AXI_WREADY) viol++;
    repeat (bstall) begin
      @(posedge clk); #1;
      if (!S_AXI_BVALID || S_AXI_BRESP !== resp || S_AXI_AWREADY ||
          S_AXI_WREADY || REG_WSTB) viol++;
    end
    @(negedge clk); S_AXI_BREADY = 1;
    @(posedge clk); #1; S_AXI_BREADY = 0;
    if (S_AXI_BVALID || !S_AXI_AWREADY || !S_AXI_WREADY || REG_WSTB) viol++;
  endtask

  task automatic bus_read(
    input logic [31:0] addr, input int ard, input int rstall,
    output logic [31:0] data, output logic [1:0] resp, output int viol);
    int cyc;
    bit hs;
    viol = 0; cyc = 0; hs = 0; data = 'x; resp = 2'b11;
    while (!hs) begin
      if (cyc >= 40) begin
        viol++; S_AXI_ARVALID = 0; return;
      end
      @(negedge clk);
      S_AXI_ARADDR = addr;
      S_AXI_ARVALID = (cyc >= ard);
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge clk);
      cyc++;
    end
    #1;
    S_AXI_ARVALID = 0;
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    if (!S_AXI_RVALID || S_AXI_ARREADY) viol++;
    repeat (rstall) begin
      @(posedge clk); #1;
      if (!S_AXI_RVALID || S_AXI_RDATA !== data ||
          S_AXI_RRESP !== resp || S_AXI_ARREADY) viol++;
    end
    @(negedge clk); S_AXI_RREADY = 1;
    @(posedge clk); #1; S_AXI_RREADY = 0;
    if (S_AXI_RVALID || !S_AXI_ARREADY) viol++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
         S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, REG_WSTB, REG_WIDX} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
         S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, REG_WSTB, REG_WIDX});
    end
    checks++;
    if (S_AXI_RDATA !== 32'h0 || REG_Q !== model_q()) begin
      errors++; $display("FAIL reset_data: rdata %h regq_nonzero %0d",
        S_AXI_RDATA, REG_Q != '0);
    end
    @(negedge clk); rst = 0; #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      errors++; $display("FAIL reset_ready_early: got %b expected 000",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge clk); #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL reset_ready_rise: got %b expected 111",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] resp; logic wstb; logic [3:0] widx; int viol;
    logic [31:0] d;
    bus_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, wstb, widx, viol);
    model_write(32'h04, 32'hDEADBEEF, 4'hF);
    checks++;
    if (resp !== 2'b00 || wstb !== 1'b1 || widx !== 4'd1 || viol != 0) begin
      errors++; $display("FAIL same_cycle_wr: resp %b wstb %b widx %0d viol %0d expected 00 1 1 0",
        resp, wstb, widx, viol);
    end
    checks++;
    if (REG_Q !== model_q()) begin
      errors++; $display("FAIL same_cycle_regq: reg1 %h expected %h",
        REG_Q[63:32], model[1]);
    end
    bus_read(32'h04, 0, 0, d, resp, viol);
    checks++;
    if (d !== 32'hDEADBEEF || resp !== 2'b00 || viol != 0) begin
      errors++; $display("FAIL same_cycle_rd: data %h resp %b viol %0d expected deadbeef 00 0",
        d, resp, viol);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] resp; logic wstb; logic [3:0] widx; int viol;
    bus_write(32'h08, 32'h12345678, 4'b0101, 3, 0, 0, resp, wstb, widx, viol);
    model_write(32'h08, 32'h12345678, 4'b0101);
    checks++;
    if (REG_Q[95:64] !== 32'h00340078 || resp !== 2'b00 || widx !== 4'd2) begin
      errors++; $display("FAIL w_first: reg2 %h resp %b widx %0d expected 00340078 00 2",
        REG_Q[95:64], resp, widx);
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL w_first_proto: violations %0d expected 0", viol);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resp; logic wstb; logic [3:0] widx; int viol;
    logic [31:0] d;
    bus_write(32'h40, 32'hCAFEF00D, 4'hF, 1, 0, 0, resp, wstb, widx, viol);
    checks++;
    if (resp !== 2'b10 || wstb !== 1'b0 || viol != 0) begin
      errors++; $display("FAIL slverr_wr: resp %b wstb %b viol %0d expected 10 0 0",
        resp, wstb, viol);
    end
    checks++;
    if (REG_Q !== model_q()) begin
      errors++; $display("FAIL slverr_regq: bank changed by rejected write");
    end
    bus_read(32'h40, 0, 0, d, resp, viol);
    checks++;
    if (d !== 32'h0 || resp !== 2'b10 || viol != 0) begin
      errors++; $display("FAIL slverr_rd: data %h resp %b viol %0d expected 0 10 0",
        d, resp, viol);
    end
  endtask

  task automatic test_stall();
    logic [1:0] resp; logic wstb; logic [3:0] widx; int viol;
    logic [31:0] d, v;
    v = $urandom;
    bus_write(32'h0C, v, 4'hF, 0, 0, 10, resp, wstb, widx, viol);
    model_write(32'h0C, v, 4'hF);
    checks++;
    if (resp !== 2'b00 || viol != 0) begin
      errors++; $display("FAIL stall_b: resp %b viol %0d expected 00 0", resp, viol);
    end
    bus_read(32'h0C, 0, 10, d, resp, viol);
    checks++;
    if (d !== model[3] || resp !== 2'b00 || viol != 0) begin
      errors++; $display("FAIL stall_r: data %h resp %b viol %0d expected %h 00 0",
        d, resp, viol, model[3]);
    end
  endtask

  task automatic test_collision();
    logic [1:0] resp; logic wstb; logic [3:0] widx; int viol;
    logic [31:0] d;
    bus_write(32'h0C, 32'h11, 4'hF, 0, 0, 0, resp, wstb, widx, viol);
    model_write(32'h0C, 32'h11, 4'hF);
    @(negedge clk);
    S_AXI_AWADDR = 32'h0C; S_AXI_WDATA = 32'h22; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 32'h0C;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    checks++;
    if (!S_AXI_RVALID || !S_AXI_BVALID || S_AXI_RDATA !== model[3]) begin
      errors++; $display("FAIL collide_old: rvalid %b bvalid %b data %h expected 1 1 %h",
        S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA, model[3]);
    end
    model_write(32'h0C, 32'h22, 4'hF);
    @(negedge clk); S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    @(posedge clk); #1; S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    bus_read(32'h0C, 0, 0, d, resp, viol);
    checks++;
    if (d !== 32'h22 || viol != 0) begin
      errors++; $display("FAIL collide_new: data %h viol %0d expected 22 0", d, viol);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, eresp; logic wstb; logic [3:0] widx; int viol;
    logic [31:0] a, d, v;
    logic [3:0] s;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = 32'h100 << $urandom_range(0, 20);
      else
        a = (32'($urandom_range(0, 17)) << 2) | 32'($urandom_range(0, 3));
      eresp = in_range(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom; s = 4'($urandom);
        bus_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), resp, wstb, widx, viol);
        model_write(a, v, s);
        checks++;
        if (resp !== eresp || wstb !== in_range(a) || viol != 0) begin
          errors++; $display("FAIL rand_wr[%0d]: addr %h resp %b wstb %b viol %0d expected %b %b 0",
            n, a, resp, wstb, viol, eresp, in_range(a));
        end
        if (in_range(a)) begin
          checks++;
          if (widx !== 4'(a >> 2)) begin
            errors++; $display("FAIL rand_widx[%0d]: got %0d expected %0d",
              n, widx, a >> 2);
          end
        end
        checks++;
        if (REG_Q !== model_q()) begin
          errors++; $display("FAIL rand_regq[%0d]: bank differs after write to %h", n, a);
        end
      end else begin
        bus_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, resp, viol);
        checks++;
        if (d !== (in_range(a) ? model[a >> 2] : 32'h0) ||
            resp !== eresp || viol != 0) begin
          errors++; $display("FAIL rand_rd[%0d]: addr %h data %h resp %b viol %0d expected %h %b 0",
            n, a, d, resp, viol, in_range(a) ? model[a >> 2] : 32'h0, eresp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] resp; int viol;
    logic [31:0] d;
    @(negedge clk);
    S_AXI_AWADDR = 32'h14; S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 32'h0C;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    checks++;
    if (!S_AXI_BVALID || !S_AXI_RVALID) begin
      errors++; $display("FAIL areset_pre: bvalid %b rvalid %b expected 1 1",
        S_AXI_BVALID, S_AXI_RVALID);
    end
    #2; rst = 1; #1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY,
         S_AXI_ARREADY, REG_WSTB} !== '0 || S_AXI_RDATA !== '0 ||
        REG_Q !== model_q()) begin
      errors++; $display("FAIL areset_drop: ctrl %b rdata %h expected 0",
        {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY,
         S_AXI_ARREADY, REG_WSTB}, S_AXI_RDATA);
    end
    @(negedge clk); #1; rst = 0; #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      errors++; $display("FAIL areset_early: readies %b expected 000",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge clk); #1;
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL areset_rise: readies %b expected 111",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    bus_read(32'h14, 0, 0, d, resp, viol);
    checks++;
    if (d !== 32'h0 || resp !== 2'b00 || viol != 0) begin
      errors++; $display("FAIL areset_read: data %h resp %b viol %0d expected 0 00 0",
        d, resp, viol);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_slverr();
    test_stall();
    test_collision();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
